// File: rtl/fetch_controller_pkg.sv
// rtl/fetch_controller_pkg.sv - shared widths, fetch state encoding and queue entry type
package fetch_controller_pkg;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;
  localparam int RESET_PC_DEF   = 0;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } fetch_state_t;

  typedef struct packed {
    logic [DATA_WIDTH_DEF-1:0] instr;
    logic [ADDR_WIDTH_DEF-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - 2-entry {instr, pc} FIFO; slot0 is always the head so outputs come straight from flops
module fetch_queue
  import fetch_controller_pkg::*;
#(
  parameter type entry_t = fetch_entry_t
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       push,
  input  entry_t     push_entry,
  input  logic       pop,
  input  logic       flush,
  output logic [1:0] count,
  output entry_t     head
);

  entry_t slot0;
  entry_t slot1;

  always_ff @(posedge clock) begin
    if (!reset) begin
      count <= 2'd0;
      slot0 <= '0;
      slot1 <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) slot0 <= push_entry;
          else               slot1 <= push_entry;
          count <= count + 2'd1;
        end
        2'b01: begin
          slot0 <= slot1;
          count <= count - 2'd1;
        end
        2'b11: begin
          // occupancy unchanged; the incoming entry lands behind whatever remains
          if (count == 2'd2) begin
            slot0 <= slot1;
            slot1 <= push_entry;
          end else begin
            slot0 <= push_entry;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = slot0;

endmodule

// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - PC sequencing, one fetch per cycle, redirect and halt/resume for the NanoRisc core
module fetch_controller
  import fetch_controller_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int RESET_PC   = RESET_PC_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [DATA_WIDTH-1:0] imem_data,
  output logic [DATA_WIDTH-1:0] instr_out,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  input  logic                  halt,
  input  logic                  resume,
  output logic                  halted
);

  typedef struct packed {
    logic [DATA_WIDTH-1:0] instr;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  fetch_state_t          state;
  fetch_state_t          state_next;
  logic [ADDR_WIDTH-1:0] pc;
  logic [ADDR_WIDTH-1:0] inflight_pc;
  logic                  inflight;
  logic [1:0]            count;
  entry_t                head;
  entry_t                push_entry;
  logic                  pop;
  logic                  push;
  logic                  issue;

  assign pop  = instr_valid & instr_ready;
  assign push = inflight & ~redirect_valid;
  assign push_entry = {imem_data, inflight_pc};

  // a slot is only promised to a new fetch if it is free once this cycle's pop retires
  assign issue = (state == ST_RUN) & ~redirect_valid & ~halt &
                 (({1'b0, count} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));

  always_comb begin
    state_next = state;
    if (halt)        state_next = ST_HALT;
    else if (resume) state_next = ST_RUN;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state       <= ST_RUN;
      pc          <= ADDR_WIDTH'(RESET_PC);
      inflight    <= 1'b0;
      inflight_pc <= '0;
      halted      <= 1'b0;
    end else begin
      state    <= state_next;
      inflight <= issue;
      halted   <= (state_next == ST_HALT) & ~issue;
      if (issue) inflight_pc <= pc;
      if (redirect_valid) pc <= redirect_target;
      else if (issue)     pc <= pc + ADDR_WIDTH'(1);
    end
  end

  fetch_queue #(
    .entry_t(entry_t)
  ) u_queue (
    .clock     (clock),
    .reset     (reset),
    .push      (push),
    .push_entry(push_entry),
    .pop       (pop),
    .flush     (redirect_valid),
    .count     (count),
    .head      (head)
  );

  assign imem_addr   = pc;
  assign instr_valid = (count != 2'd0);
  assign instr_out   = head.instr;
  assign instr_pc    = head.pc;

endmodule
